// File: rtl/tinker_io_pkg.sv
// Shared defaults and helpers for the programmed-I/O port and its FIFOs.
package tinker_io_pkg;

    localparam int unsigned DATA_W_DEFAULT = 64;

    // Occupancy counters need one extra bit so that a full FIFO (level == DEPTH) is representable.
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/tinker_io_port_fifo.sv
// Single-clock FIFO with combinational head; push into a full FIFO is allowed when a pop happens in the same cycle.
module io_fifo
    import tinker_io_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head,
    output logic [level_w(DEPTH)-1:0]  level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = level_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/tinker_io_port.sv
// Peripheral side of the CPU programmed-I/O port: CPU writes feed a TX FIFO, CPU reads drain an RX FIFO.
module tinker_io_port
    import tinker_io_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       out_signal,
    input  logic [DATA_W-1:0]          out_data,
    input  logic                       in_signal,
    output logic [DATA_W-1:0]          in_data,
    output logic                       tx_valid,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_ready,
    input  logic                       rx_valid,
    input  logic [DATA_W-1:0]          rx_data,
    output logic                       rx_ready,
    output logic [level_w(DEPTH)-1:0]  tx_level,
    output logic [level_w(DEPTH)-1:0]  rx_level,
    output logic                       overflow,
    output logic                       underflow
);

    logic              out_prev;
    logic              in_prev;
    logic              out_evt;
    logic              in_evt;
    logic              tx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic              rx_push;
    logic              rx_full;
    logic              rx_empty;
    logic [DATA_W-1:0] rx_head;

    assign out_evt  = out_signal & ~out_prev;
    assign in_evt   = in_signal & ~in_prev;
    assign tx_valid = ~tx_empty;
    assign tx_pop   = tx_valid & tx_ready;
    assign rx_ready = ~rx_full;
    assign rx_push  = rx_valid & rx_ready;
    // The CPU samples in_data in the same cycle it raises in_signal, so the head must be visible combinationally.
    assign in_data  = rx_empty ? '0 : rx_head;

    io_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_tx (
        .clk       (clk),
        .reset     (reset),
        .push      (out_evt),
        .push_data (out_data),
        .pop       (tx_ready),
        .head      (tx_data),
        .level     (tx_level),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    io_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (in_evt),
        .head      (rx_head),
        .level     (rx_level),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_prev  <= 1'b0;
            in_prev   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out_prev <= out_signal;
            in_prev  <= in_signal;
            if (out_evt && tx_full && !tx_pop) begin
                overflow <= 1'b1;
            end
            if (in_evt && rx_empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tinker_io_port.sv
// Randomized and directed bench for tinker_io_port against a queue-based model of the port.
module tb_tinker_io_port;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 64;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          out_signal, in_signal, tx_ready, rx_valid;
    logic [DW-1:0] out_data, rx_data;
    logic [DW-1:0] in_data, tx_data;
    logic          tx_valid, rx_ready, overflow, underflow;
    logic [LW-1:0] tx_level, rx_level;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] txq[$];
    logic [DW-1:0] rxq[$];
    bit            m_ovf, m_unf, m_oprev, m_iprev;

    always #5 clk = ~clk;

    tinker_io_port #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .out_signal (out_signal),
        .out_data   (out_data),
        .in_signal  (in_signal),
        .in_data    (in_data),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .tx_level   (tx_level),
        .rx_level   (rx_level),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("tx_level", DW'(tx_level), DW'(txq.size()));
        check("rx_level", DW'(rx_level), DW'(rxq.size()));
        check("tx_valid", DW'(tx_valid), DW'(txq.size() != 0));
        if (txq.size() != 0) check("tx_data", tx_data, txq[0]);
        check("in_data", in_data, (rxq.size() != 0) ? rxq[0] : '0);
        check("rx_ready", DW'(rx_ready), DW'(rxq.size() != DEPTH));
        check("overflow", DW'(overflow), DW'(m_ovf));
        check("underflow", DW'(underflow), DW'(m_unf));
    endtask

    // Applies the port's rules to the queues for one clock edge with the given inputs.
    task automatic model_step(input bit os, input logic [DW-1:0] od, input bit is,
                              input bit tr, input bit rv, input logic [DW-1:0] rd);
        bit oe, ie, tpop, rpush;
        int tsz, rsz;
        oe    = os && !m_oprev;
        ie    = is && !m_iprev;
        tsz   = txq.size();
        rsz   = rxq.size();
        tpop  = (tsz != 0) && tr;
        rpush = rv && (rsz != DEPTH);
        if (tpop) void'(txq.pop_front());
        if (oe) begin
            if (tsz < DEPTH || tpop) txq.push_back(od);
            else m_ovf = 1;
        end
        if (ie) begin
            if (rsz != 0) void'(rxq.pop_front());
            else m_unf = 1;
        end
        if (rpush) rxq.push_back(rd);
        m_oprev = os;
        m_iprev = is;
    endtask

    task automatic model_clear();
        txq.delete();
        rxq.delete();
        m_ovf = 0; m_unf = 0; m_oprev = 0; m_iprev = 0;
    endtask

    task automatic cycle(input bit os, input logic [DW-1:0] od, input bit is,
                         input bit tr, input bit rv, input logic [DW-1:0] rd);
        out_signal = os; out_data = od; in_signal = is;
        tx_ready = tr; rx_valid = rv; rx_data = rd;
        #1;
        compare_all();
        @(posedge clk);
        model_step(os, od, is, tr, rv, rd);
        @(negedge clk);
    endtask

    task automatic write_word(input logic [DW-1:0] d, input bit tr);
        cycle(1, d, 0, tr, 0, '0);
        cycle(0, '0, 0, tr, 0, '0);
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b0;
        out_signal = 0; in_signal = 0; tx_ready = 0; rx_valid = 0;
        out_data = '0; rx_data = '0;
        model_clear();
        #1;
        compare_all();
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b0;
        out_signal = 0; in_signal = 0; tx_ready = 0; rx_valid = 0;
        out_data = '0; rx_data = '0;
        model_clear();
        @(negedge clk);
        apply_reset(3);
        check("rst_rx_ready", DW'(rx_ready), 1);

        // Three writes held in TX, then drained.
        write_word(64'h11, 0);
        write_word(64'h22, 0);
        write_word(64'h33, 0);
        check("tx3_level", DW'(tx_level), 3);
        check("tx3_head", tx_data, 64'h11);
        repeat (4) cycle(0, '0, 0, 1, 0, '0);
        check("tx_drained", DW'(tx_valid), 0);

        // Overflow on the ninth write, drain yields 1..8.
        for (int i = 1; i <= 9; i++) write_word(DW'(i), 0);
        check("ovf_level", DW'(tx_level), DEPTH);
        check("ovf_flag", DW'(overflow), 1);
        for (int i = 1; i <= 8; i++) begin
            check("ovf_drain", tx_data, DW'(i));
            cycle(0, '0, 0, 1, 0, '0);
        end

        // Write coinciding with a pop while full is accepted.
        apply_reset(1);
        for (int i = 0; i < 8; i++) write_word(DW'(64'h100 + i), 0);
        cycle(1, 64'hABC, 0, 1, 0, '0);
        check("full_pop_level", DW'(tx_level), DEPTH);
        check("full_pop_ovf", DW'(overflow), 0);
        repeat (9) cycle(0, '0, 0, 1, 0, '0);

        // RX fill and CPU reads.
        cycle(0, '0, 0, 0, 1, 64'hAA);
        check("rx_first", in_data, 64'hAA);
        cycle(0, '0, 0, 0, 1, 64'hBB);
        cycle(0, '0, 1, 0, 0, '0);
        check("rx_second", in_data, 64'hBB);
        cycle(0, '0, 0, 0, 0, '0);
        cycle(0, '0, 1, 0, 0, '0);
        check("rx_empty_data", in_data, 0);
        check("rx_empty_level", DW'(rx_level), 0);
        cycle(0, '0, 0, 0, 0, '0);
        cycle(0, '0, 1, 0, 0, '0);
        check("underflow", DW'(underflow), 1);
        cycle(0, '0, 0, 0, 0, '0);

        // Held in_signal pops exactly once; push-while-empty with read underflows and keeps the word.
        cycle(0, '0, 0, 0, 1, 64'h5);
        cycle(0, '0, 0, 0, 1, 64'h6);
        repeat (4) cycle(0, '0, 1, 0, 0, '0);
        check("held_in_level", DW'(rx_level), 1);
        cycle(0, '0, 0, 0, 0, '0);
        cycle(0, '0, 1, 0, 0, '0);
        cycle(0, '0, 0, 0, 0, '0);
        cycle(0, '0, 1, 0, 1, 64'h77);
        check("push_empty_read", in_data, 64'h77);

        // Asynchronous reset in the middle of a drain.
        apply_reset(1);
        for (int i = 0; i < 5; i++) write_word(DW'(i + 1), 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0, 1, DW'(64'hC0 + i));
        out_signal = 0; in_signal = 0; tx_ready = 1; rx_valid = 0;
        @(posedge clk);
        model_step(0, '0, 0, 1, 0, '0);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check("async_tx_level", DW'(tx_level), 0);
        check("async_rx_level", DW'(rx_level), 0);
        check("async_tx_valid", DW'(tx_valid), 0);
        tx_ready = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        write_word(64'h7, 0);
        check("post_reset_tx", tx_data, 64'h7);
        cycle(0, '0, 0, 1, 0, '0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) apply_reset(1);
            cycle($urandom_range(0, 2) == 0, {$urandom, $urandom}, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, {$urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
